word_assembler: RTL
===================

Name: word_assembler

Overview:
- Sits directly upstream of the DTW word matcher. Turns the per-frame letter stream from the gesture classifier into a packed 120-bit word.
- Filters the stream with a stability/debounce filter and supports backspace and clear.
- On end-of-word, issues a one-cycle start to DTW and holds the word stable until DTW reports finish.

Parameters:
- STABLE_CNT, 4: consecutive identical valid samples needed to accept a letter; legal range 1..15.
- MAX_LEN, 15: maximum characters per word; fixed by the 120-bit DTW word (15 x 8 bits).

Ports:
- i_WA_clk  in  1  clock.
- i_WA_rst_n  in  1  reset, synchronous, active-low.
- i_WA_valid  in  1  classifier sample strobe.
- i_WA_letter  in  5  classifier code: 0 = no letter, 1..26 = A..Z, 27..31 = invalid (treated as 0).
- i_WA_commit  in  1  end-of-word pulse.
- i_WA_delete  in  1  backspace pulse.
- i_WA_clear  in  1  discard the current word.
- i_WA_dtw_finish  in  1  DTW finish flag (o_DTW_finish).
- o_WA_start  out  1  one-cycle start to DTW (i_DTW_start).
- o_WA_word  out  120  packed word to DTW (i_DTW_word).
- o_WA_length  out  4  current character count, 0..15.
- o_WA_busy  out  1  high while a word is in flight to DTW.
- o_WA_overflow  out  1  sticky: a letter was dropped because the word was full.
- o_WA_state  out  2  current FSM state, for debug.

Behaviour:
- Reset (synchronous, i_WA_rst_n=0 at a clock edge):
  - state=COLLECT; all outputs 0.
  - Filter registers prev=0, cnt=0.
  - Applies in any state, including mid-WAIT. DTW shares the reset.
- Word packing:
  - Char i occupies o_WA_word[8i+7:8i] as {3'b000, code}; char 0 is in bits [7:0].
  - Unused bytes are 0.
- Stability filter (runs in every state, only on i_WA_valid=1):
  - Code c is first mapped: 27..31 become 0.
  - If c==prev: cnt saturates at STABLE_CNT. Otherwise: prev<=c, cnt<=1.
  - Accept pulse fires when cnt's new value equals STABLE_CNT and its old value was below it, and c!=0.
  - This gives at most one accept per run. A double letter needs an intervening different code, e.g. 0.
  - With STABLE_CNT=1, a new code is accepted on its first sample.
- States: COLLECT=0, ISSUE=1, WAIT=2.
- COLLECT, per-cycle priority clear > commit > delete > append; lower-priority events in the same cycle are dropped.
  - clear: word=0, length=0, overflow=0.
  - commit with length>0: go to ISSUE. commit with length==0: ignored.
  - delete with length>0: byte[length-1]<=0, length-1. delete with length==0: no-op.
  - append on accept with length<15: byte[length]<=code, length+1.
  - append on accept with length==15: letter dropped, overflow<=1.
- ISSUE (exactly one cycle): o_WA_start=1, o_WA_busy=1; next state WAIT.
- WAIT:
  - o_WA_busy=1; word and length frozen.
  - accept, delete, clear and commit are all ignored.
  - i_WA_dtw_finish=1: word=0, length=0, overflow=0, next state COLLECT.
- Timing and outputs:
  - i_WA_dtw_finish is sampled only in WAIT.
  - Latency: commit sampled at edge N gives o_WA_start=1 and o_WA_busy=1 during cycle N+1, and o_WA_start=0 from N+2.
  - Word is stable from cycle N+1 until the cycle after finish.
  - All outputs are registered or decoded from state only; no combinational path from any input to any output.

Test Plan:
- STABLE_CNT=4; feed R x4, 0, E x4, 0, S x4, then commit -> length=3, o_WA_word[23:0]=0x130512 and upper bits 0; start high exactly one cycle, the cycle after commit; busy stays 1 until finish; after finish, word=0, length=0, state=COLLECT.
- Filter: A x3 then B x3 -> nothing accepted. A x10 -> exactly one A, length=1.
- Double letter: L x8 continuous -> one L. L x4, 0, L x4 -> two Ls, word[15:0]=0x0C0C.
- Overflow: accept 16 distinct-run letters -> length=15, byte14=15th letter, overflow=1. Then delete -> length=14, byte14=0, overflow still 1. Then clear -> all 0.
- Handshake: commit at length 0 -> no start. In WAIT, feed letters, delete and clear -> word unchanged. Commit and delete in the same COLLECT cycle -> commit wins, length unchanged.
- Reset mid-WAIT: hold i_WA_rst_n=0 for one edge -> next cycle word=0, busy=0, start=0, state=COLLECT.

Source files
------------

// File: rtl/word_assembler.sv
// Debounces the classifier letter stream and packs accepted letters into a 120-bit word.
// Handles backspace/clear, then hands the word to DTW with a one-cycle start and holds it until finish.
module word_assembler #(
  parameter int STABLE_CNT = 4,
  parameter int MAX_LEN    = 15
) (
  input  logic                 i_WA_clk,
  input  logic                 i_WA_rst_n,
  input  logic                 i_WA_valid,
  input  logic [4:0]           i_WA_letter,
  input  logic                 i_WA_commit,
  input  logic                 i_WA_delete,
  input  logic                 i_WA_clear,
  input  logic                 i_WA_dtw_finish,
  output logic                 o_WA_start,
  output logic [8*MAX_LEN-1:0] o_WA_word,
  output logic [3:0]           o_WA_length,
  output logic                 o_WA_busy,
  output logic                 o_WA_overflow,
  output logic [1:0]           o_WA_state
);

  // state   | meaning
  // COLLECT | filtering letters, editing the word
  // ISSUE   | single cycle, start pulse to DTW
  // WAIT    | word frozen until DTW finishes
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2
  } state_e;

  localparam int         WORD_W   = 8 * MAX_LEN;
  localparam logic [3:0] STABLE_C = 4'(STABLE_CNT);
  localparam logic [3:0] MAX_C    = 4'(MAX_LEN);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [3:0]          len_q, len_d;
  logic                ovf_q, ovf_d;
  logic [4:0]          prev_q, prev_d;
  logic [3:0]          cnt_q, cnt_d;

  logic [4:0]          code_c;
  logic [3:0]          run_old;
  logic                accept;

  assign code_c = (i_WA_letter > 5'd26) ? 5'd0 : i_WA_letter;

  // run_old is the length of the current run before this sample, so a fresh
  // code counts from zero and STABLE_CNT=1 accepts on the first sample.
  always_comb begin
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    run_old = 4'd0;
    accept  = 1'b0;
    if (i_WA_valid) begin
      if (code_c == prev_q) begin
        run_old = cnt_q;
        cnt_d   = (cnt_q >= STABLE_C) ? STABLE_C : cnt_q + 4'd1;
      end else begin
        prev_d = code_c;
        cnt_d  = 4'd1;
      end
      accept = (cnt_d == STABLE_C) && (run_old < STABLE_C) && (code_c != 5'd0);
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    case (state_q)
      COLLECT: begin
        if (i_WA_clear) begin
          word_d = '0;
          len_d  = 4'd0;
          ovf_d  = 1'b0;
        end else if (i_WA_commit) begin
          if (len_q != 4'd0) state_d = ISSUE;
        end else if (i_WA_delete) begin
          if (len_q != 4'd0) begin
            len_d = len_q - 4'd1;
            for (int b = 0; b < MAX_LEN; b++) begin
              if (4'(b) == len_q - 4'd1) word_d[8*b +: 8] = 8'h00;
            end
          end
        end else if (accept) begin
          if (len_q < MAX_C) begin
            len_d = len_q + 4'd1;
            for (int b = 0; b < MAX_LEN; b++) begin
              if (4'(b) == len_q) word_d[8*b +: 8] = {3'b000, code_c};
            end
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (i_WA_dtw_finish) begin
          word_d  = '0;
          len_d   = 4'd0;
          ovf_d   = 1'b0;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge i_WA_clk) begin
    if (!i_WA_rst_n) begin
      state_q <= COLLECT;
      word_q  <= '0;
      len_q   <= 4'd0;
      ovf_q   <= 1'b0;
      prev_q  <= 5'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_WA_start    = (state_q == ISSUE);
  assign o_WA_busy     = (state_q != COLLECT);
  assign o_WA_word     = word_q;
  assign o_WA_length   = len_q;
  assign o_WA_overflow = ovf_q;
  assign o_WA_state    = state_q;

endmodule
